// File: rtl/cpu_stack_if.sv
// ============================================================================
// Module   : cpu_stack_if
// Brief    : Operation, status and loop-counter bundle for cpu_stack_engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cpu_stack_if #(
   parameter int W      = 32,
   parameter int DEPTH  = 256,
   parameter int N_LOOP = 2,
   parameter int LW     = 16
);
   localparam int DW = $clog2(DEPTH) + 1;
   localparam int SW = (N_LOOP > 1) ? $clog2(N_LOOP) : 1;

   logic [3:0]    op;
   logic [W-1:0]  din;
   logic [W-1:0]  tos;
   logic [W-1:0]  nos;
   logic [DW-1:0] depth;
   logic          empty;
   logic          full;
   logic          ovf;
   logic          unf;
   logic          clr_err;
   logic          lp_ld;
   logic          lp_dec;
   logic [SW-1:0] lp_sel;
   logic          lp_nz;
   logic [LW-1:0] lp_val;

   modport master (
      output op, din, clr_err, lp_ld, lp_dec, lp_sel,
      input  tos, nos, depth, empty, full, ovf, unf, lp_nz, lp_val
   );

   modport slave (
      input  op, din, clr_err, lp_ld, lp_dec, lp_sel,
      output tos, nos, depth, empty, full, ovf, unf, lp_nz, lp_val
   );
endinterface

`default_nettype wire

// File: rtl/cpu_stack_engine.sv
// ============================================================================
// Module   : cpu_stack_engine
// Brief    : Register-cached data stack (TOS/NOS in flops, rest in sync RAM)
//            with sticky over/underflow flags and a bank of loop counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_stack_engine #(
   parameter int W      = 32,
   parameter int DEPTH  = 256,
   parameter int N_LOOP = 2,
   parameter int LW     = 16
) (
   input  wire logic   clk,
   input  wire logic   rst,
   cpu_stack_if.slave  bus
);
   localparam int DW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);
   localparam int SW = (N_LOOP > 1) ? $clog2(N_LOOP) : 1;

   localparam logic [3:0] OP_PUSH    = 4'd1;
   localparam logic [3:0] OP_POP     = 4'd2;
   localparam logic [3:0] OP_DUP     = 4'd3;
   localparam logic [3:0] OP_SWAP    = 4'd4;
   localparam logic [3:0] OP_OVER    = 4'd5;
   localparam logic [3:0] OP_ROT     = 4'd6;
   localparam logic [3:0] OP_REPLACE = 4'd7;
   localparam logic [3:0] OP_BINOP   = 4'd8;

   logic [DW-1:0] depth_q, depth_nx, need;
   logic [W-1:0]  tos_q, nos_q, third_q, tos_nx, nos_nx;
   logic          ovf_q, unf_q, ovf_set, unf_set, grow;
   logic          wr_en;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [W-1:0]  wr_data;
   logic [W-1:0]  mem [DEPTH];
   logic [LW-1:0] lp_q [N_LOOP];
   logic [LW-1:0] lp_val_w;

   always_comb begin
      grow = 1'b0;
      need = '0;
      case (bus.op)
         OP_PUSH:    grow = 1'b1;
         OP_POP:     need = DW'(1);
         OP_DUP:     begin grow = 1'b1; need = DW'(1); end
         OP_SWAP:    need = DW'(2);
         OP_OVER:    begin grow = 1'b1; need = DW'(2); end
         OP_ROT:     need = DW'(3);
         OP_REPLACE: need = DW'(1);
         OP_BINOP:   need = DW'(2);
         default:    need = '0;
      endcase
   end

   always_comb begin
      depth_nx = depth_q;
      tos_nx   = tos_q;
      nos_nx   = nos_q;
      wr_en    = 1'b0;
      wr_addr  = AW'(depth_q - DW'(2));
      wr_data  = nos_q;
      ovf_set  = 1'b0;
      unf_set  = 1'b0;
      if (grow && depth_q == DW'(DEPTH)) begin
         ovf_set = 1'b1;
      end else if (depth_q < need) begin
         unf_set = 1'b1;
      end else begin
         // Growing ops spill the old NOS into RAM; shrinking ops refill NOS from the cached third entry.
         case (bus.op)
            OP_PUSH: begin
               tos_nx   = bus.din;
               nos_nx   = tos_q;
               wr_en    = (depth_q >= DW'(2));
               depth_nx = depth_q + DW'(1);
            end
            OP_POP: begin
               tos_nx   = nos_q;
               nos_nx   = third_q;
               depth_nx = depth_q - DW'(1);
            end
            OP_DUP: begin
               nos_nx   = tos_q;
               wr_en    = (depth_q >= DW'(2));
               depth_nx = depth_q + DW'(1);
            end
            OP_SWAP: begin
               tos_nx = nos_q;
               nos_nx = tos_q;
            end
            OP_OVER: begin
               tos_nx   = nos_q;
               nos_nx   = tos_q;
               wr_en    = 1'b1;
               depth_nx = depth_q + DW'(1);
            end
            OP_ROT: begin
               tos_nx  = third_q;
               nos_nx  = tos_q;
               wr_en   = 1'b1;
               wr_addr = AW'(depth_q - DW'(3));
            end
            OP_REPLACE: tos_nx = bus.din;
            OP_BINOP: begin
               tos_nx   = bus.din;
               nos_nx   = third_q;
               depth_nx = depth_q - DW'(1);
            end
            default: depth_nx = depth_q;
         endcase
      end
   end

   // Reading at next-depth minus 3 keeps third_q aligned with the third entry one cycle later.
   assign rd_addr = AW'(depth_nx - DW'(3));

   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[wr_addr] <= wr_data;
      end
      third_q <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         depth_q <= '0;
         tos_q   <= '0;
         nos_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         depth_q <= depth_nx;
         tos_q   <= tos_nx;
         nos_q   <= nos_nx;
         ovf_q   <= ovf_set | (ovf_q & ~bus.clr_err);
         unf_q   <= unf_set | (unf_q & ~bus.clr_err);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_LOOP; i++) begin
         if (rst) begin
            lp_q[i] <= '0;
         end else if (bus.lp_sel == SW'(i)) begin
            if (bus.lp_ld) begin
               lp_q[i] <= bus.din[LW-1:0];
            end else if (bus.lp_dec) begin
               lp_q[i] <= lp_q[i] - LW'(1);
            end
         end
      end
   end

   // Out-of-range selects match no counter and therefore read as zero.
   always_comb begin
      lp_val_w = '0;
      for (int i = 0; i < N_LOOP; i++) begin
         if (bus.lp_sel == SW'(i)) begin
            lp_val_w = lp_q[i];
         end
      end
   end

   assign bus.tos    = tos_q;
   assign bus.nos    = nos_q;
   assign bus.depth  = depth_q;
   assign bus.empty  = (depth_q == '0);
   assign bus.full   = (depth_q == DW'(DEPTH));
   assign bus.ovf    = ovf_q;
   assign bus.unf    = unf_q;
   assign bus.lp_val = lp_val_w;
   assign bus.lp_nz  = |lp_val_w;

endmodule

`default_nettype wire

// File: tb/tb_cpu_stack_engine.sv
// ============================================================================
// Module   : tb_cpu_stack_engine
// Brief    : Directed vector table plus model-checked random run for the stack engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_stack_engine;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    op;
   logic [W-1:0]  din;
   logic          clr_err, lp_ld, lp_dec;
   logic [1:0]    lp_sel;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   cpu_stack_if #(.W(W), .DEPTH(256), .N_LOOP(2), .LW(16)) bif ();
   cpu_stack_if #(.W(W), .DEPTH(4),   .N_LOOP(3), .LW(16)) sif ();

   assign bif.op = op;       assign sif.op = op;
   assign bif.din = din;     assign sif.din = din;
   assign bif.clr_err = clr_err; assign sif.clr_err = clr_err;
   assign bif.lp_ld = lp_ld; assign sif.lp_ld = lp_ld;
   assign bif.lp_dec = lp_dec; assign sif.lp_dec = lp_dec;
   assign bif.lp_sel = lp_sel[0];
   assign sif.lp_sel = lp_sel;

   cpu_stack_engine #(.W(W), .DEPTH(256), .N_LOOP(2), .LW(16)) u_big (
      .clk(clk), .rst(rst), .bus(bif)
   );
   cpu_stack_engine #(.W(W), .DEPTH(4), .N_LOOP(3), .LW(16)) u_small (
      .clk(clk), .rst(rst), .bus(sif)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] din;
      logic        clr;
      logic [31:0] tos;
      logic [31:0] nos;
      int          depth;
      logic        ovf;
      logic        unf;
   } vec_t;

   vec_t         vecs[$];
   logic [31:0]  ms[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      op = 4'd0; din = '0; clr_err = 1'b0; lp_ld = 1'b0; lp_dec = 1'b0; lp_sel = 2'd0;
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;

      chk("rst depth", bif.depth, 0);
      chk("rst empty", bif.empty, 1);
      chk("rst full", bif.full, 0);
      chk("rst tos", bif.tos, 0);
      chk("rst nos", bif.nos, 0);
      chk("rst flags", {bif.ovf, bif.unf}, 0);
      chk("rst small depth", sif.depth, 0);

      // Directed table on the DEPTH=4 instance: {op, din, clr, tos, nos, depth, ovf, unf}
      vecs = '{
         '{4'd1, 32'h11, 1'b0, 32'h11, 32'h0,  1, 1'b0, 1'b0},
         '{4'd1, 32'h22, 1'b0, 32'h22, 32'h11, 2, 1'b0, 1'b0},
         '{4'd1, 32'h33, 1'b0, 32'h33, 32'h22, 3, 1'b0, 1'b0},
         '{4'd6, 32'h0,  1'b0, 32'h11, 32'h33, 3, 1'b0, 1'b0},
         '{4'd2, 32'h0,  1'b0, 32'h33, 32'h22, 2, 1'b0, 1'b0},
         '{4'd2, 32'h0,  1'b0, 32'h22, 32'h0,  1, 1'b0, 1'b0},
         '{4'd2, 32'h0,  1'b0, 32'h0,  32'h0,  0, 1'b0, 1'b0},
         '{4'd1, 32'h1,  1'b0, 32'h1,  32'h0,  1, 1'b0, 1'b0},
         '{4'd1, 32'h2,  1'b0, 32'h2,  32'h1,  2, 1'b0, 1'b0},
         '{4'd1, 32'h3,  1'b0, 32'h3,  32'h2,  3, 1'b0, 1'b0},
         '{4'd1, 32'h4,  1'b0, 32'h4,  32'h3,  4, 1'b0, 1'b0},
         '{4'd1, 32'h5,  1'b0, 32'h4,  32'h3,  4, 1'b1, 1'b0},
         '{4'd1, 32'h5,  1'b1, 32'h4,  32'h3,  4, 1'b1, 1'b0},
         '{4'd2, 32'h0,  1'b0, 32'h3,  32'h2,  3, 1'b1, 1'b0},
         '{4'd2, 32'h0,  1'b0, 32'h2,  32'h1,  2, 1'b1, 1'b0},
         '{4'd2, 32'h0,  1'b0, 32'h1,  32'h0,  1, 1'b1, 1'b0},
         '{4'd2, 32'h0,  1'b0, 32'h0,  32'h0,  0, 1'b1, 1'b0},
         '{4'd2, 32'h0,  1'b0, 32'h0,  32'h0,  0, 1'b1, 1'b1},
         '{4'd0, 32'h0,  1'b1, 32'h0,  32'h0,  0, 1'b0, 1'b0},
         '{4'd1, 32'h5,  1'b0, 32'h5,  32'h0,  1, 1'b0, 1'b0},
         '{4'd1, 32'h7,  1'b0, 32'h7,  32'h5,  2, 1'b0, 1'b0},
         '{4'd8, 32'hC,  1'b0, 32'hC,  32'h0,  1, 1'b0, 1'b0},
         '{4'd5, 32'h0,  1'b0, 32'hC,  32'h0,  1, 1'b0, 1'b1},
         '{4'd0, 32'h0,  1'b1, 32'hC,  32'h0,  1, 1'b0, 1'b0},
         '{4'd4, 32'h0,  1'b0, 32'hC,  32'h0,  1, 1'b0, 1'b1},
         '{4'd0, 32'h0,  1'b1, 32'hC,  32'h0,  1, 1'b0, 1'b0},
         '{4'd3, 32'h0,  1'b0, 32'hC,  32'hC,  2, 1'b0, 1'b0},
         '{4'd7, 32'h9,  1'b0, 32'h9,  32'hC,  2, 1'b0, 1'b0},
         '{4'd4, 32'h0,  1'b0, 32'hC,  32'h9,  2, 1'b0, 1'b0},
         '{4'd5, 32'h0,  1'b0, 32'h9,  32'hC,  3, 1'b0, 1'b0},
         '{4'd1, 32'h6,  1'b0, 32'h6,  32'h9,  4, 1'b0, 1'b0},
         '{4'd12, 32'h4D, 1'b0, 32'h6, 32'h9,  4, 1'b0, 1'b0},
         '{4'd2, 32'h0,  1'b0, 32'h9,  32'hC,  3, 1'b0, 1'b0},
         '{4'd8, 32'h3,  1'b0, 32'h3,  32'h9,  2, 1'b0, 1'b0},
         '{4'd2, 32'h0,  1'b0, 32'h9,  32'h0,  1, 1'b0, 1'b0},
         '{4'd2, 32'h0,  1'b0, 32'h0,  32'h0,  0, 1'b0, 1'b0}
      };

      foreach (vecs[i]) begin
         op = vecs[i].op; din = vecs[i].din; clr_err = vecs[i].clr;
         tick();
         chk($sformatf("v%0d depth", i), sif.depth, vecs[i].depth);
         chk($sformatf("v%0d empty", i), sif.empty, vecs[i].depth == 0);
         chk($sformatf("v%0d full", i), sif.full, vecs[i].depth == 4);
         chk($sformatf("v%0d ovf", i), sif.ovf, vecs[i].ovf);
         chk($sformatf("v%0d unf", i), sif.unf, vecs[i].unf);
         if (vecs[i].depth >= 1) chk($sformatf("v%0d tos", i), sif.tos, vecs[i].tos);
         if (vecs[i].depth >= 2) chk($sformatf("v%0d nos", i), sif.nos, vecs[i].nos);
      end
      op = 4'd0; clr_err = 1'b0;

      // Random PUSH/POP/DUP against a queue model on the DEPTH=256 instance
      rst = 1'b1; tick(); rst = 1'b0;
      ms.delete();
      for (int c = 0; c < 1000; c++) begin
         int r;
         r = $urandom_range(0, 3);
         din = $urandom();
         if (ms.size() == 0)        op = 4'd1;
         else if (ms.size() == 256) op = 4'd2;
         else if (r < 2)            op = 4'd1;
         else if (r == 2)           op = 4'd2;
         else                       op = 4'd3;
         tick();
         case (op)
            4'd1:    ms.push_back(din);
            4'd2:    void'(ms.pop_back());
            default: ms.push_back(ms[ms.size()-1]);
         endcase
         chk("rnd depth", bif.depth, ms.size());
         chk("rnd flags", {bif.ovf, bif.unf}, 0);
         if (ms.size() >= 1) chk("rnd tos", bif.tos, ms[ms.size()-1]);
         if (ms.size() >= 2) chk("rnd nos", bif.nos, ms[ms.size()-2]);
      end
      op = 4'd0;

      // Loop counters
      rst = 1'b1; tick(); rst = 1'b0;
      lp_sel = 2'd1; lp_ld = 1'b1; din = 32'h3;
      tick();
      lp_ld = 1'b0;
      chk("lp load", bif.lp_val, 16'h3);
      for (int k = 0; k < 4; k++) begin
         lp_dec = 1'b1;
         #1;
         chk($sformatf("lp_nz before dec %0d", k), bif.lp_nz, (k < 3));
         tick();
      end
      lp_dec = 1'b0;
      #1;
      chk("lp wrap", bif.lp_val, 16'hFFFF);
      lp_sel = 2'd0;
      #1;
      chk("lp other untouched", bif.lp_val, 16'h0);
      lp_sel = 2'd1; lp_ld = 1'b1; lp_dec = 1'b1; din = 32'h9;
      tick();
      lp_ld = 1'b0; lp_dec = 1'b0;
      chk("lp ld wins", bif.lp_val, 16'h9);

      lp_sel = 2'd3; lp_ld = 1'b1; din = 32'h5;
      #1;
      chk("lp oob val", sif.lp_val, 16'h0);
      chk("lp oob nz", sif.lp_nz, 1'b0);
      tick();
      lp_ld = 1'b0; lp_sel = 2'd2;
      #1;
      chk("lp oob no load", sif.lp_val, 16'h0);
      lp_sel = 2'd1;
      #1;
      chk("lp small ctr1", sif.lp_val, 16'h9);

      // Reset in the middle of a PUSH burst
      lp_sel = 2'd0; lp_ld = 1'b1; din = 32'h55;
      op = 4'd2;
      tick();
      lp_ld = 1'b0;
      chk("pre unf", bif.unf, 1'b1);
      for (int k = 0; k < 100; k++) begin
         op = 4'd1; din = k + 1;
         tick();
      end
      chk("burst depth", bif.depth, 100);
      chk("burst tos", bif.tos, 100);
      din = 32'hBEEF; rst = 1'b1;
      tick();
      rst = 1'b0; op = 4'd0;
      chk("mid rst depth", bif.depth, 0);
      chk("mid rst tos", bif.tos, 0);
      chk("mid rst nos", bif.nos, 0);
      chk("mid rst flags", {bif.ovf, bif.unf}, 0);
      lp_sel = 2'd0;
      #1;
      chk("mid rst lp0", bif.lp_val, 0);
      lp_sel = 2'd1;
      #1;
      chk("mid rst lp1", bif.lp_val, 0);
      op = 4'd1; din = 32'hA;
      tick();
      op = 4'd0;
      chk("post rst tos", bif.tos, 32'hA);
      chk("post rst depth", bif.depth, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/cpu_stack_engine.md
Name: cpu_stack_engine

Overview:
- Parametrised data-stack plus loop-counter engine for the next-generation embedded stack CPU.
- Replaces the fixed 32-bit, 256-entry, two-counter arrangement with configurable width, depth and loop-counter count.
- Adds occupancy tracking, overflow/underflow protection with sticky error flags, and a single-cycle binary-op collapse.
- Sits between instruction decode/ALU and the stack BRAM; TOS/NOS are held in registers, deeper entries in inferred synchronous RAM.

Parameters:
- W, 32, data word width in bits.
- DEPTH, 256, maximum stack entries, including TOS and NOS; a power of 2, >= 4.
- N_LOOP, 2, number of loop counters; >= 1.
- LW, 16, loop counter width; LW <= W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- op  in  4  stack operation code; encodings below.
- din  in  W  operand for PUSH, REPLACE, BINOP.
- tos  out  W  top of stack, registered.
- nos  out  W  next on stack, registered.
- depth  out  clog2(DEPTH)+1  current entry count, 0..DEPTH.
- empty  out  1  depth == 0.
- full  out  1  depth == DEPTH.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.
- clr_err  in  1  clears ovf and unf.
- lp_ld  in  1  load loop counter lp_sel from din[LW-1:0].
- lp_dec  in  1  decrement loop counter lp_sel.
- lp_sel  in  clog2(N_LOOP) (min 1)  loop counter index.
- lp_nz  out  1  combinational: counter[lp_sel] != 0, value before any update this cycle.
- lp_val  out  LW  combinational: counter[lp_sel].

Behaviour:
- Op encodings, with depth change and minimum depth required:
  - 0 NOP: 0 change, min 0.
  - 1 PUSH: +1, min 0. tos<=din, nos<=tos.
  - 2 POP: -1, min 1. tos<=nos, nos<=mem.
  - 3 DUP: +1, min 1. nos<=tos.
  - 4 SWAP: 0, min 2. Exchange tos and nos.
  - 5 OVER: +1, min 2. tos<=nos, nos<=tos.
  - 6 ROT: 0, min 3. (a b c -> b c a), with c = tos: tos<=third, nos<=old tos, third<=old nos.
  - 7 REPLACE: 0, min 1. tos<=din.
  - 8 BINOP: -1, min 2. tos<=din, nos<=mem; din is the ALU result of tos/nos.
  - 9-15: treated as NOP.
- Timing:
  - One op accepted every clock, no stalls or bubbles.
  - tos, nos and depth reflect the op on the following edge.
  - RAM read address is derived from the next depth value, so the third entry is always available combinationally one cycle later.
- Overflow: a +1 op when depth == DEPTH is suppressed entirely (no state change) and sets ovf on the same edge.
- Underflow: an op when depth < its minimum depth is suppressed and sets unf.
- Undefined contents: when depth < 2, nos contents are don't-care; when depth < 1, tos contents are don't-care. The bench must not check them.
- Error flags: ovf and unf stay set until clr_err or rst. clr_err in the same cycle as a new error leaves the flag set (set wins).
- Reset, including mid-operation: depth=0, tos=0, nos=0, ovf=0, unf=0, all loop counters=0. The RAM is not cleared.
- Loop counters:
  - lp_ld loads counter[lp_sel] from din[LW-1:0].
  - lp_dec: counter[lp_sel] <= counter[lp_sel] - 1, modulo 2^LW, so 0 wraps to all-ones.
  - lp_ld and lp_dec together: the load wins.
  - Loop ops are independent of stack ops; both may occur in the same cycle.
- lp_sel >= N_LOOP: loads and decrements are ignored; lp_nz=0, lp_val=0.
- Arithmetic: depth is unsigned and never leaves 0..DEPTH. Internally the RAM write pointer is depth-2, used only when depth >= 2.

Test Plan:
- Reset, then PUSH 0x11, 0x22, 0x33 -> tos=0x33, nos=0x22, depth=3. ROT -> tos=0x11, nos=0x33, depth=3. POP, POP -> tos=0x22, depth=1.
- DEPTH=4: PUSH 1..4 -> full=1. PUSH 5 -> ovf=1, tos=4, depth=4. POP x4 -> empty=1. POP -> unf=1, depth=0. clr_err -> ovf=0, unf=0.
- Depth 2 (tos=7, nos=5): BINOP with din=12 -> tos=12, depth=1. OVER -> unf=1, state unchanged. SWAP at depth 1 -> unf=1.
- Back-to-back PUSH/POP/DUP every cycle for 1000 random cycles against a reference model -> tos, nos and depth match every cycle; no error flags while depth stays within 0..DEPTH.
- lp_ld counter1=3, then lp_dec x4 -> lp_nz before each decrement = 1,1,1,0, counter ends at 0xFFFF. lp_ld and lp_dec together with din=9 -> counter=9.
- Assert rst during a PUSH burst at depth 100 -> next cycle depth=0, tos=0, flags=0, counters=0. Next PUSH 0xA -> tos=0xA, depth=1.
